// File: rtl/dma_write_engine.sv
// dma_write_engine: writes an accepted stream of WIDTH-bit words to consecutive memory word addresses.
// Optional running checksum of acknowledged words is enabled by defining DMA_CSUM_EN.
module dma_write_engine #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [LEN_W-1:0]  cfg_len,
  output logic              busy,
  output logic              done,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              valid_in,
  output logic              ready_in,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic              mem_we,
  input  logic              mem_ack,
  output logic [LEN_W-1:0]  words_written
`ifdef DMA_CSUM_EN
  ,
  output logic [WIDTH-1:0]  csum
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    WAIT_ACK,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] base_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  count_q;
  logic [LEN_W-1:0]  count_inc;
  logic              start_take;
  logic              word_take;
  logic              ack_take;

  assign count_inc  = count_q + LEN_W'(1);
  assign start_take = (state == IDLE) && cfg_start;
  assign word_take  = (state == XFER) && valid_in;
  // mem_we is high for the whole of WAIT_ACK, so an ack anywhere else is a stray
  assign ack_take   = (state == WAIT_ACK) && mem_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ready_in  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    mem_we    = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_start) begin
          state_nxt = (cfg_len == '0) ? DONE : XFER;
        end
      end
      XFER: begin
        ready_in = 1'b1;
        busy     = 1'b1;
        if (valid_in) begin
          state_nxt = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        busy   = 1'b1;
        mem_we = 1'b1;
        if (mem_ack) begin
          state_nxt = (count_inc == len_q) ? DONE : XFER;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q  <= '0;
      len_q   <= '0;
      count_q <= '0;
    end else if (start_take) begin
      base_q  <= cfg_base_addr;
      len_q   <= cfg_len;
      count_q <= '0;
    end else if (ack_take) begin
      count_q <= count_inc;
    end
  end

  // Address is base plus words already acknowledged, wrapping naturally at ADDR_W bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (word_take) begin
      mem_addr  <= base_q + ADDR_W'(count_q);
      mem_wdata <= data_in;
    end
  end

  assign words_written = count_q;

`ifdef DMA_CSUM_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      csum <= '0;
    end else if (start_take) begin
      csum <= '0;
    end else if (ack_take) begin
      csum <= csum + mem_wdata;
    end
  end
`endif

endmodule

// File: tb/tb_dma_write_engine.sv
// tb_dma_write_engine: randomized stimulus with a queue scoreboard checked by a decoupled monitor.
// Checks the csum output as well when DMA_CSUM_EN is defined.
module tb_dma_write_engine;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 16;
  localparam int LEN_W  = 8;

  logic              clk;
  logic              rst;
  logic              cfg_start;
  logic [ADDR_W-1:0] cfg_base_addr;
  logic [LEN_W-1:0]  cfg_len;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  data_in;
  logic              valid_in;
  logic              ready_in;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_wdata;
  logic              mem_we;
  logic              mem_ack;
  logic [LEN_W-1:0]  words_written;
`ifdef DMA_CSUM_EN
  logic [WIDTH-1:0]  csum;
`endif

  dma_write_engine #(
    .WIDTH (WIDTH),
    .ADDR_W(ADDR_W),
    .LEN_W (LEN_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_start    (cfg_start),
    .cfg_base_addr(cfg_base_addr),
    .cfg_len      (cfg_len),
    .busy         (busy),
    .done         (done),
    .data_in      (data_in),
    .valid_in     (valid_in),
    .ready_in     (ready_in),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_ack      (mem_ack),
    .words_written(words_written)
`ifdef DMA_CSUM_EN
    ,
    .csum         (csum)
`endif
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  data;
  } wr_t;

  typedef struct {
    logic [LEN_W-1:0] count;
    logic [WIDTH-1:0] sum;
    bit               had_writes;
  } done_t;

  wr_t   exp_wr[$];
  done_t exp_done[$];

  int total = 0;
  int bad = 0;
  int forced_delay = -1;
  bit stray_en = 0;
  int cycle = 0;
  int done_seen = 0;
  int last_ack_cycle = -10;

  logic              prev_we;
  logic              prev_ack;
  logic              prev_done;
  logic [ADDR_W-1:0] prev_addr;
  logic [WIDTH-1:0]  prev_data;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Memory model: acks after a random (or forced) number of wait cycles, plus optional stray acks
  initial begin
    int cnt;
    cnt = -1;
    mem_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        mem_ack = 1'b0;
        cnt = -1;
      end else if (mem_we) begin
        if (cnt < 0) cnt = (forced_delay >= 0) ? forced_delay : int'($urandom_range(0, 3));
        if (cnt == 0) begin
          mem_ack = 1'b1;
          cnt = -1;
        end else begin
          mem_ack = 1'b0;
          cnt--;
        end
      end else begin
        mem_ack = stray_en && ($urandom_range(0, 1) == 1);
      end
    end
  end

  // Monitor: pops the scoreboard on every accepted write and every done pulse
  always @(negedge clk) begin
    done_t d;
    wr_t   w;
    cycle++;
    if (!rst) begin
      prev_we   = 1'b0;
      prev_ack  = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (mem_we) begin
        checkOutput("ready_low_during_write", ready_in, 0);
        checkOutput("busy_during_write", busy, 1);
        if (prev_we && !prev_ack) begin
          checkOutput("addr_stable", mem_addr, prev_addr);
          checkOutput("data_stable", mem_wdata, prev_data);
        end
      end
      if (mem_we && mem_ack) begin
        checkOutput("write_expected", exp_wr.size() > 0, 1);
        if (exp_wr.size() > 0) begin
          w = exp_wr.pop_front();
          checkOutput("write_addr", mem_addr, w.addr);
          checkOutput("write_data", mem_wdata, w.data);
        end
        last_ack_cycle = cycle;
      end
      if (done) begin
        done_seen++;
        checkOutput("done_single_cycle", prev_done, 0);
        checkOutput("busy_low_at_done", busy, 0);
        checkOutput("done_expected", exp_done.size() > 0, 1);
        if (exp_done.size() > 0) begin
          d = exp_done.pop_front();
          checkOutput("done_words_written", words_written, d.count);
`ifdef DMA_CSUM_EN
          checkOutput("done_csum", csum, d.sum);
`endif
          if (d.had_writes) checkOutput("done_after_last_ack", cycle - last_ack_cycle, 1);
        end
      end
      prev_we   = mem_we;
      prev_ack  = mem_ack;
      prev_done = done;
      prev_addr = mem_addr;
      prev_data = mem_wdata;
    end
  end

  task automatic feedWord(input logic [WIDTH-1:0] w, input int gap, output bit ok);
    int budget;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    valid_in = 1'b1;
    data_in  = w;
    budget = 200;
    ok = 1'b0;
    while (budget > 0 && !ok) begin
      @(negedge clk);
      if (ready_in) ok = 1'b1;
      budget--;
    end
    checkOutput("word_accepted_in_time", ok, 1);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    data_in  = WIDTH'($urandom);
  endtask

  task automatic startXfer(input logic [ADDR_W-1:0] base, input int len);
    @(posedge clk);
    #1;
    cfg_start     = 1'b1;
    cfg_base_addr = base;
    cfg_len       = LEN_W'(len);
    @(posedge clk);
    #1;
    cfg_start     = 1'b0;
    cfg_base_addr = ADDR_W'($urandom);
    cfg_len       = LEN_W'($urandom);
  endtask

  // Reference model: word i lands at (base + i) mod 2^ADDR_W; checksum is the plain sum of all words
  task automatic applyStimulus(input logic [ADDR_W-1:0] base, input int len, input bit inject,
                               input bit fixed, input logic [WIDTH-1:0] seed);
    logic [WIDTH-1:0] words[$];
    logic [WIDTH-1:0] sum;
    wr_t   w;
    done_t d;
    bit    ok;
    sum = '0;
    for (int i = 0; i < len; i++) begin
      words.push_back(fixed ? seed + WIDTH'(i) : WIDTH'($urandom));
      w.addr = ADDR_W'((int'(base) + i) % (1 << ADDR_W));
      w.data = words[i];
      exp_wr.push_back(w);
      sum = sum + words[i];
    end
    d.count = LEN_W'(len);
    d.sum = sum;
    d.had_writes = (len > 0);
    exp_done.push_back(d);
    startXfer(base, len);
    for (int i = 0; i < len; i++) begin
      if (inject && i == 1) begin
        @(posedge clk);
        #1;
        cfg_start     = 1'b1;
        cfg_base_addr = 16'h0100;
        cfg_len       = LEN_W'($urandom_range(0, 255));
        @(posedge clk);
        #1;
        cfg_start     = 1'b0;
      end
      feedWord(words[i], int'($urandom_range(0, 2)), ok);
      if (!ok) break;
    end
  endtask

  task automatic waitDone(input int budget);
    int start;
    start = done_seen;
    while (budget > 0 && done_seen == start) begin
      @(negedge clk);
      #1;
      budget--;
    end
    checkOutput("done_arrived", done_seen > start, 1);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  n;
    bit  ok;
    logic [WIDTH-1:0] rw[4];
    wr_t w;
    rst           = 1'b1;
    cfg_start     = 1'b0;
    cfg_base_addr = '0;
    cfg_len       = '0;
    data_in       = '0;
    valid_in      = 1'b0;

    // Asynchronous reset asserted mid-cycle
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_ready", ready_in, 0);
    checkOutput("reset_we", mem_we, 0);
    checkOutput("reset_addr", mem_addr, 0);
    checkOutput("reset_wdata", mem_wdata, 0);
    checkOutput("reset_words", words_written, 0);
`ifdef DMA_CSUM_EN
    checkOutput("reset_csum", csum, 0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Idle engine never takes stream words
    @(posedge clk);
    #1;
    valid_in = 1'b1;
    data_in  = 32'hDEAD_BEEF;
    repeat (4) begin
      @(negedge clk);
      checkOutput("idle_ready", ready_in, 0);
      checkOutput("idle_busy", busy, 0);
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;

    $display("[TB] basic transfer");
    forced_delay = 0;
    applyStimulus(16'h0010, 3, 1'b0, 1'b1, 32'hA0);
    waitDone(200);
    checkOutput("basic_words_held", words_written, 3);
`ifdef DMA_CSUM_EN
    checkOutput("basic_csum", csum, 32'h1E3);
`endif

    $display("[TB] ack stall");
    forced_delay = 5;
    applyStimulus(ADDR_W'($urandom), 1, 1'b0, 1'b0, '0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!mem_we) break;
      n++;
    end
    checkOutput("stall_we_cycles", n, 6);
    waitDone(50);
    forced_delay = -1;

    $display("[TB] address wrap and zero length");
    applyStimulus(16'hFFFF, 2, 1'b0, 1'b0, '0);
    waitDone(200);
    applyStimulus(16'h1234, 0, 1'b0, 1'b0, '0);
    checkOutput("zero_len_done_next_cycle", done, 1);
    waitDone(10);
    checkOutput("zero_len_words", words_written, 0);

    $display("[TB] start while busy and stray acks");
    forced_delay = 0;
    stray_en = 1'b1;
    applyStimulus(16'h0200, 5, 1'b1, 1'b0, '0);
    waitDone(300);
    stray_en = 1'b0;
    forced_delay = -1;

    $display("[TB] reset mid-transfer");
    forced_delay = 3;
    for (int i = 0; i < 4; i++) begin
      rw[i] = WIDTH'($urandom);
      w.addr = ADDR_W'(16'h0300 + i);
      w.data = rw[i];
      exp_wr.push_back(w);
    end
    startXfer(16'h0300, 4);
    feedWord(rw[0], 0, ok);
    feedWord(rw[1], 0, ok);
    n = 0;
    while (n < 20 && !mem_we) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("midreset_we", mem_we, 0);
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_ready", ready_in, 0);
    checkOutput("midreset_words", words_written, 0);
    exp_wr.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    forced_delay = -1;
    applyStimulus(ADDR_W'($urandom), 1, 1'b0, 1'b0, '0);
    waitDone(100);

    $display("[TB] maximum length");
    applyStimulus(ADDR_W'($urandom), 255, 1'b0, 1'b0, '0);
    waitDone(4000);
    checkOutput("max_len_words", words_written, 255);

    $display("[TB] random transfers");
    repeat (20) begin
      n = int'($urandom_range(0, 9));
      applyStimulus(ADDR_W'($urandom), n, (n >= 2) && ($urandom_range(0, 1) == 1), 1'b0, '0);
      waitDone(400);
    end

    repeat (3) @(negedge clk);
    checkOutput("writes_drained", exp_wr.size(), 0);
    checkOutput("dones_drained", exp_done.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
